// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: M->W payload record, register-slice state and width defaults.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RD_W_DEFAULT = 5;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] result;
    logic [XLEN_DEFAULT-1:0] load;
    logic [RD_W_DEFAULT-1:0] rd;
    logic [XLEN_DEFAULT-1:0] pc4;
  } mw_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mw_state_e;

endpackage

// File: rtl/pipe_stage_mw_if.sv
// M->W handshake bus: upstream payload in, W-stage payload out, stall counter.
interface pipe_stage_mw_if import riscv_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RD_W  = RD_W_DEFAULT,
  parameter int CNT_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] arith_result_m;
  logic [XLEN-1:0] load_data_m;
  logic [XLEN-1:0] pc_plus4_m;
  logic [RD_W-1:0] rd_m;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] arith_result_w;
  logic [XLEN-1:0] load_data_w;
  logic [XLEN-1:0] pc_plus4_w;
  logic [RD_W-1:0] rd_w;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, arith_result_m, load_data_m, pc_plus4_m, rd_m, out_ready,
    input  in_ready, out_valid, arith_result_w, load_data_w, pc_plus4_w, rd_w, stall_cnt
  );

  modport slave (
    input  in_valid, arith_result_m, load_data_m, pc_plus4_m, rd_m, out_ready,
    output in_ready, out_valid, arith_result_w, load_data_w, pc_plus4_w, rd_w, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (inc && (cnt != {W{1'b1}})) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_stage_mw.sv
// M->W pipeline register slice with a skid entry, so in_ready is a pure register output.
module pipe_stage_mw import riscv_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RD_W  = RD_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  pipe_stage_mw_if.slave bus
);

  mw_state_e   state, state_n;
  mw_payload_t main_q, skid_q, in_pl;
  logic        main_v, skid_v, in_ready_q;
  logic        in_xfer, out_xfer;
  logic        ld_main_in, ld_main_skid, ld_skid;

  assign in_pl    = '{result: bus.arith_result_m, load: bus.load_data_m,
                      rd: bus.rd_m, pc4: bus.pc_plus4_m};
  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = main_v & bus.out_ready;

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          state_n    = ONE;
          ld_main_in = 1'b1;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            ld_main_in = 1'b1;
          end else if (out_xfer) begin
            state_n = EMPTY;
          end else if (in_xfer) begin
            state_n = TWO;
            ld_skid = 1'b1;
          end
        end
        TWO: if (out_xfer && skid_v) begin
          state_n      = ONE;
          ld_main_skid = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // in_ready and the valid bits are registered decodes of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      main_v     <= (state_n != EMPTY);
      skid_v     <= (state_n == TWO);
      in_ready_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_pl;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_pl;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = main_v;
  assign bus.arith_result_w = main_q.result;
  assign bus.load_data_w    = main_q.load;
  assign bus.pc_plus4_w     = main_q.pc4;
  // a bubble must never look like a write to a real register
  assign bus.rd_w           = main_v ? main_q.rd : '0;

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v & ~bus.out_ready),
    .cnt   (bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_mw.sv
// Directed vector table plus corner sequences and a queue-scoreboarded random run.
module tb_pipe_stage_mw;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset, flush, rst2;
  always #5 clk = ~clk;

  pipe_stage_mw_if #(.CNT_W(16)) bus ();
  pipe_stage_mw_if #(.CNT_W(4))  bus2 ();

  pipe_stage_mw #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );
  pipe_stage_mw #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(rst2), .flush(1'b0), .bus(bus2)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        ov;
    logic [4:0]  rdw;
    logic [31:0] aw;
    logic        ir;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt[8];

  mw_payload_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] a, input logic [4:0] rd);
    bus.in_valid       = iv;
    bus.out_ready      = ordy;
    flush              = fl;
    bus.arith_result_m = a;
    bus.load_data_m    = a ^ 32'hA5A5_0000;
    bus.pc_plus4_m     = a + 32'd4;
    bus.rd_m           = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // expected state after each edge, starting from EMPTY
    vt[0] = '{1'b1, 1'b1, 32'h11, 5'd7, 1'b1, 5'd7, 32'h11, 1'b1, 16'd0};
    vt[1] = '{1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 5'd0, 32'h11, 1'b1, 16'd0};
    vt[2] = '{1'b1, 1'b0, 32'h1,  5'd1, 1'b1, 5'd1, 32'h1,  1'b1, 16'd0};
    vt[3] = '{1'b1, 1'b0, 32'h2,  5'd2, 1'b1, 5'd1, 32'h1,  1'b0, 16'd1};
    vt[4] = '{1'b1, 1'b0, 32'h5,  5'd5, 1'b1, 5'd1, 32'h1,  1'b0, 16'd2};
    vt[5] = '{1'b0, 1'b1, 32'h0,  5'd0, 1'b1, 5'd2, 32'h2,  1'b1, 16'd2};
    vt[6] = '{1'b1, 1'b1, 32'h6,  5'd6, 1'b1, 5'd6, 32'h6,  1'b1, 16'd2};
    vt[7] = '{1'b0, 1'b1, 32'h0,  5'd0, 1'b0, 5'd0, 32'h6,  1'b1, 16'd2};

    reset = 1'b1;
    rst2  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus2.arith_result_m = 32'h0; bus2.load_data_m = 32'h0;
    bus2.pc_plus4_m = 32'h0; bus2.rd_m = 5'd0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_rd_w",      32'(bus.rd_w), 32'd0);
    chk("rst_arith_w",   bus.arith_result_w, 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].iv, vt[i].ordy, 1'b0, vt[i].a, vt[i].rd);
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      chk($sformatf("vec%0d_rd_w", i),      32'(bus.rd_w), 32'(vt[i].rdw));
      chk($sformatf("vec%0d_arith_w", i),   bus.arith_result_w, vt[i].aw);
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready), 32'(vt[i].ir));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(bus.stall_cnt), 32'(vt[i].cnt));
    end

    // flush in TWO drops both held entries and the same-cycle input
    drive(1'b1, 1'b0, 1'b0, 32'h1, 5'd1); step();
    drive(1'b1, 1'b0, 1'b0, 32'h2, 5'd2); step();
    chk("fl_pre_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h3, 5'd3); step();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_rd_w",      32'(bus.rd_w), 32'd0);
    chk("fl_in_ready",  32'(bus.in_ready), 32'd1);
    chk("fl_stall_kept", 32'(bus.stall_cnt), 32'd4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 5'd0); step();
      chk($sformatf("fl_idle%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h8, 5'd8); step();
    chk("fl_next_rd_w",    32'(bus.rd_w), 32'd8);
    chk("fl_next_arith_w", bus.arith_result_w, 32'h8);

    // asynchronous reset between edges while in TWO
    drive(1'b1, 1'b0, 1'b0, 32'h21, 5'd3); step();
    drive(1'b1, 1'b0, 1'b0, 32'h22, 5'd4); step();
    chk("ar_pre_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_rd_w",      32'(bus.rd_w), 32'd0);
    chk("ar_in_ready",  32'(bus.in_ready), 32'd0);
    chk("ar_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    #3 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 5'd0); step();
    chk("ar_rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_rel_in_ready",  32'(bus.in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h44, 5'd9); step();
    chk("ar_new_rd_w",    32'(bus.rd_w), 32'd9);
    chk("ar_new_arith_w", bus.arith_result_w, 32'h44);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 5'd0); step();
    chk("ar_drain_out_valid", 32'(bus.out_valid), 32'd0);

    // 4-bit stall counter saturates at 15
    rst2 = 1'b0;
    step();
    bus2.in_valid = 1'b1; bus2.rd_m = 5'd1;
    step();
    bus2.in_valid = 1'b0;
    chk("sat_out_valid", 32'(bus2.out_valid), 32'd1);
    repeat (10) step();
    chk("sat_cnt10", 32'(bus2.stall_cnt), 32'd10);
    repeat (10) step();
    chk("sat_cnt20", 32'(bus2.stall_cnt), 32'd15);
    repeat (5) step();
    chk("sat_cnt25", 32'(bus2.stall_cnt), 32'd15);

    // random traffic against a reference queue
    reset = 1'b1;
    #2 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    step();
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      logic iv, ordy, fl, acc;
      logic [31:0] a;
      logic [4:0]  rd;
      mw_payload_t p;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      a    = $urandom;
      rd   = 5'($urandom_range(0, 31));
      drive(iv, ordy, fl, a, rd);
      acc = iv && (q.size() < 2);
      if (fl) begin
        q.delete();
      end else begin
        if (ordy && q.size() > 0) void'(q.pop_front());
        if (acc) begin
          p = '{result: a, load: a ^ 32'hA5A5_0000, rd: rd, pc4: a + 32'd4};
          q.push_back(p);
        end
      end
      step();
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("rnd_in_ready",  32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        chk("rnd_arith_w", bus.arith_result_w, q[0].result);
        chk("rnd_load_w",  bus.load_data_w, q[0].load);
        chk("rnd_pc4_w",   bus.pc_plus4_w, q[0].pc4);
        chk("rnd_rd_w",    32'(bus.rd_w), 32'(q[0].rd));
      end else begin
        chk("rnd_bubble_rd_w", 32'(bus.rd_w), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_mw.md
PIPE_STAGE_MW -- requirements
Module: pipe_stage_mw

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, giving the width of the result, load-data and pc_plus4 fields.
REQ-002 The block SHALL have parameter RD_W, default 5, giving the destination-register index width.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.

Ports:
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  discard all held entries.
REQ-007 in_valid  in  1  the upstream (M) entry is valid.
REQ-008 in_ready  out  1  the block can accept the upstream entry.
REQ-009 arith_result_m, load_data_m, pc_plus4_m  in  XLEN each  M-stage payload fields.
REQ-010 rd_m  in  RD_W  M-stage destination register index.
REQ-011 out_valid  out  1  the W-stage entry is valid.
REQ-012 out_ready  in  1  the W stage consumes the entry.
REQ-013 arith_result_w, load_data_w, pc_plus4_w  out  XLEN each  W-stage payload fields.
REQ-014 rd_w  out  RD_W  W-stage destination register index.
REQ-015 stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Transfers SHALL occur only on valid&ready: input on in_valid&in_ready, output on out_valid&out_ready.
REQ-017 Storage SHALL be two entries, MAIN (drives the outputs) and SKID; the state SHALL be one of EMPTY, ONE (MAIN valid) or TWO (MAIN and SKID valid).
REQ-018 in_ready SHALL be driven directly from a register and SHALL equal 1 exactly when the state is not TWO; it SHALL have no combinational path from out_ready.
REQ-019 Latency SHALL be one cycle: an entry accepted in EMPTY SHALL appear on the outputs with out_valid=1 in the next cycle.
REQ-020 EMPTY SHALL go to ONE on an input transfer and otherwise stay EMPTY.
REQ-021 ONE with input and output transfer together SHALL load MAIN from the input and stay ONE.
REQ-022 ONE with an output transfer only SHALL go to EMPTY.
REQ-023 ONE with an input transfer only SHALL write SKID and go to TWO.
REQ-024 TWO with an output transfer SHALL move SKID into MAIN and go to ONE; no input is accepted in TWO.
REQ-025 Entries SHALL leave in strict arrival order, with no loss and no duplication.
REQ-026 flush SHALL take priority over every transfer: the next state SHALL be EMPTY, a same-cycle input SHALL be dropped, and in_ready SHALL be 1 in the following cycle.
REQ-027 While out_valid=0, rd_w SHALL read 0 (x0) so that a bubble never triggers forwarding or a register-file write; the other payload outputs SHALL hold their last value.
REQ-028 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, SHALL saturate at all-ones without wrapping, and SHALL be cleared only by reset (flush does not clear it).

Reset
REQ-029 reset SHALL act immediately, without waiting for a clock edge, and force the state to EMPTY.
REQ-030 While reset is asserted, out_valid SHALL be 0, in_ready SHALL be 0, and all payload outputs, rd_w and stall_cnt SHALL be 0.
REQ-031 in_ready SHALL rise in the first clock cycle after reset deasserts.
REQ-032 A reset asserted in state TWO SHALL discard both entries; no held entry SHALL appear after reset deasserts.

Structure
REQ-033 XLEN and RD_W defaults, a packed struct mw_payload_t (result, load, rd, pc4) and the state enum SHALL be defined in the shared package riscv_pkg.
REQ-034 The saturating counter SHALL be implemented as one sub-module, sat_counter, parametrised by CNT_W.
REQ-035 MAIN and SKID SHALL each be held as one mw_payload_t register plus a valid bit; all state SHALL be in always_ff blocks with asynchronous reset.

Verification
REQ-036 Reset, then in_valid=1, rd_m=7, arith_result_m=0x11, out_ready=1 -> next cycle out_valid=1, rd_w=7, arith_result_w=0x11.
REQ-037 With out_ready=0, push A=0x1 then B=0x2 -> in_ready=0 after B, stall_cnt increments each cycle; raise out_ready -> A then B on consecutive cycles, no loss.
REQ-038 Hold state TWO, assert flush together with in_valid=1 and C=0x3 -> next cycle out_valid=0, rd_w=0, in_ready=1; C never appears.
REQ-039 With CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15, then stays at 15.
REQ-040 In state TWO, assert reset between clock edges -> out_valid=0 and rd_w=0 immediately; after release, the first output is the next newly pushed entry.
REQ-041 Drive random in_valid/out_ready for 10k cycles against a reference queue -> outputs match in order, and rd_w=0 whenever out_valid=0.
